wb_timer_multi: RTL and testbench

// - Multi-channel Wishbone (classic) slave timer; successor to the single-threshold timer.
// - Shared programmable prescaler drives NUM_CHANNELS independent down-counters, one-shot or periodic.
// - Per-channel sticky status, a mask, and one combined level IRQ to the core interrupt input.

---
 rtl/wb_timer_multi_if.sv | 30 +++
 rtl/wb_timer_multi.sv | 220 ++++++++++++++++++++++
 tb/tb_wb_timer_multi.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_timer_multi_if.sv
// Wishbone classic bus bundle for wb_timer_multi.
// Signal names follow the slave's point of view (_i into the slave, _o out of it).
//   wb_addr_i  word address        wb_data_i  write data
//   wb_we_i    write enable        wb_sel_i   byte lanes
//   wb_stb_i   strobe              wb_cyc_i   cycle
//   wb_ack_o   acknowledge         wb_data_o  read data, valid with ack
interface wb_timer_multi_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 4
);
    logic [ADDR_W-1:0] wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              wb_we_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic              wb_stb_i;
    logic              wb_cyc_i;
    logic              wb_ack_o;
    logic [DATA_W-1:0] wb_data_o;

    modport master (
        output wb_addr_i, wb_data_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_ack_o, wb_data_o
    );

    modport slave (
        input  wb_addr_i, wb_data_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_ack_o, wb_data_o
    );
endinterface

// File: rtl/wb_timer_multi.sv
// Multi-channel Wishbone (classic) timer.
// A shared prescaler produces ticks that decrement NUM_CHANNELS independent
// down-counters. Each expiry sets a sticky STATUS bit and pulses ch_event_o;
// timer_irq_o is the registered OR of STATUS & MASK.
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   wb           Wishbone slave (wb_timer_multi_if.slave)
//   timer_irq_o  combined level interrupt, registered
//   ch_event_o   one-cycle pulse per channel expiry
//
// Register map (byte offsets, only addr[7:2] decoded):
//   0x00 GCTRL[0] global enable   0x04 PRESCALE   0x08 STATUS (W1C)   0x0C MASK
//   0x20+8n LOAD(n)   0x24+8n CTRL(n) [0]=en [1]=periodic   0x80+4n COUNT(n) (RO)
//
// Build option: define WB_TIMER_AUTORELOAD_EN to implement CTRL[1] (periodic
// reload). Without it CTRL[1] reads 0 and every channel is one-shot.
module wb_timer_multi #(
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_SEL_WIDTH   = 4,
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    wb_timer_multi_if.slave         wb,
    output logic                    timer_irq_o,
    output logic [NUM_CHANNELS-1:0] ch_event_o
);

    localparam int unsigned DW = WB_DATA_WIDTH;
    localparam int unsigned AW = WB_ADDR_WIDTH;
    localparam int unsigned SW = WB_SEL_WIDTH;
    localparam int unsigned NC = NUM_CHANNELS;
    localparam int unsigned PW = PRESCALE_WIDTH;

    // Register state
    logic          ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          irq_q, irq_d;
    logic [NC-1:0] event_q, event_d;
    logic          gen_q, gen_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [NC-1:0] status_q, status_d;
    logic [NC-1:0] mask_q, mask_d;
    logic [DW-1:0] load_q  [NC];
    logic [DW-1:0] load_d  [NC];
    logic [DW-1:0] count_q [NC];
    logic [DW-1:0] count_d [NC];
    logic [NC-1:0] en_q, en_d;
    logic [NC-1:0] per_q, per_d;

    // Decode / helper nets
    logic          access_c;
    logic          wr_c;
    logic          rd_c;
    logic [5:0]    idx_c;
    logic          tick_c;
    logic [NC-1:0] load_wr_c;
    logic [NC-1:0] ctrl_wr_c;
    logic [NC-1:0] status_clr_c;
    logic [DW-1:0] rdata_c;
    logic          unused_addr_c;

    // Replace the byte lanes selected by sel, keep the others.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] sel);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < int'(SW); b++) begin
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    // One access per ack; the ack itself blocks re-triggering so stb is re-sampled.
    assign access_c      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr_c          = access_c & wb.wb_we_i;
    assign rd_c          = access_c & ~wb.wb_we_i;
    assign idx_c         = wb.wb_addr_i[7:2];
    assign unused_addr_c = ^{wb.wb_addr_i[AW-1:8], wb.wb_addr_i[1:0]};

    // >= rather than == so a PRESCALE shrink below pcnt cannot stall the ticks.
    assign tick_c = gen_q && (pcnt_q >= prescale_q);

    // Per-channel write strobes
    always_comb begin
        load_wr_c = '0;
        ctrl_wr_c = '0;
        for (int n = 0; n < int'(NC); n++) begin
            load_wr_c[n] = wr_c && (idx_c == 6'(8 + 2 * n));
            ctrl_wr_c[n] = wr_c && wb.wb_sel_i[0] && (idx_c == 6'(9 + 2 * n));
        end
    end

    // Read mux; unmapped and non-existent channel addresses return 0
    always_comb begin
        rdata_c = '0;
        case (idx_c)
            6'd0:    rdata_c = DW'(gen_q);
            6'd1:    rdata_c = DW'(prescale_q);
            6'd2:    rdata_c = DW'(status_q);
            6'd3:    rdata_c = DW'(mask_q);
            default: ;
        endcase
        for (int n = 0; n < int'(NC); n++) begin
            if (idx_c == 6'(8 + 2 * n)) rdata_c = load_q[n];
            if (idx_c == 6'(9 + 2 * n)) rdata_c = DW'({per_q[n], en_q[n]});
            if (idx_c == 6'(32 + n))    rdata_c = count_q[n];
        end
    end

    // Next-state logic for bus, prescaler and channels
    always_comb begin
        ack_d        = access_c;
        rdata_d      = rd_c ? rdata_c : '0;
        irq_d        = |(status_q & mask_q);
        gen_d        = gen_q;
        prescale_d   = prescale_q;
        pcnt_d       = '0;
        mask_d       = mask_q;
        status_clr_c = '0;
        load_d       = load_q;
        count_d      = count_q;
        en_d         = en_q;
        per_d        = per_q;
        event_d      = '0;

        if (wr_c) begin
            case (idx_c)
                6'd0: if (wb.wb_sel_i[0]) gen_d = wb.wb_data_i[0];
                6'd1: prescale_d = PW'(merge_bytes(DW'(prescale_q), wb.wb_data_i, wb.wb_sel_i));
                6'd2: if (wb.wb_sel_i[0]) status_clr_c = wb.wb_data_i[NC-1:0];
                6'd3: if (wb.wb_sel_i[0]) mask_d = wb.wb_data_i[NC-1:0];
                default: ;
            endcase
        end

        if (gen_q) pcnt_d = tick_c ? '0 : pcnt_q + PW'(1);

        for (int n = 0; n < int'(NC); n++) begin
            // LOAD only matters at the next start or reload
            if (load_wr_c[n]) load_d[n] = merge_bytes(load_q[n], wb.wb_data_i, wb.wb_sel_i);

            if (ctrl_wr_c[n]) begin
`ifdef WB_TIMER_AUTORELOAD_EN
                per_d[n] = wb.wb_data_i[1];
`endif
                if (!wb.wb_data_i[0]) begin
                    en_d[n] = 1'b0;
                end else if (!en_q[n] && (load_q[n] != '0)) begin
                    en_d[n]    = 1'b1;
                    count_d[n] = load_q[n];
                end
            end

            // A stop write in the same cycle freezes COUNT and suppresses the tick
            if (tick_c && en_q[n] && !(ctrl_wr_c[n] && !wb.wb_data_i[0])) begin
                if (count_q[n] == DW'(1)) begin
                    event_d[n] = 1'b1;
                    count_d[n] = '0;
                    if (per_q[n] && (load_q[n] != '0)) count_d[n] = load_q[n];
                    else                               en_d[n]    = 1'b0;
                end else if (count_q[n] != '0) begin
                    count_d[n] = count_q[n] - DW'(1);
                end
            end
        end

        // Expiry set beats a same-cycle W1C
        status_d = (status_q & ~status_clr_c) | event_d;
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            event_q    <= '0;
            gen_q      <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            en_q       <= '0;
            per_q      <= '0;
            for (int n = 0; n < int'(NC); n++) begin
                load_q[n]  <= '0;
                count_q[n] <= '0;
            end
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            event_q    <= event_d;
            gen_q      <= gen_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            status_q   <= status_d;
            mask_q     <= mask_d;
            en_q       <= en_d;
            per_q      <= per_d;
            for (int n = 0; n < int'(NC); n++) begin
                load_q[n]  <= load_d[n];
                count_q[n] <= count_d[n];
            end
        end
    end

    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_data_o = rdata_q;
    assign timer_irq_o  = irq_q;
    assign ch_event_o   = event_q;

endmodule

// File: tb/tb_wb_timer_multi.sv
// Directed bench for wb_timer_multi. Bus transactions push their expected read
// data into a scoreboard queue; a monitor pops and compares on every ack.
module tb_wb_timer_multi;

    logic       clk;
    logic       rst_n;
    logic       timer_irq;
    logic [3:0] ch_event;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q  [$];
    string       name_q [$];

    wb_timer_multi_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) wb_if ();

    wb_timer_multi #(
        .WB_DATA_WIDTH (32),
        .WB_ADDR_WIDTH (32),
        .WB_SEL_WIDTH  (4),
        .NUM_CHANNELS  (4),
        .PRESCALE_WIDTH(16)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wb         (wb_if.slave),
        .timer_irq_o(timer_irq),
        .ch_event_o (ch_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, expv);
        end
    endtask

    // One bus transaction; expected read data (if chk) goes to the scoreboard.
    task automatic bus(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel, input logic chk, input logic [31:0] expv,
                       input string name);
        bit got;
        exp_q.push_back({chk, expv});
        name_q.push_back(name);
        wb_if.wb_addr_i = {24'h0, addr};
        wb_if.wb_data_i = wdata;
        wb_if.wb_sel_i  = sel;
        wb_if.wb_we_i   = we;
        wb_if.wb_cyc_i  = 1'b1;
        wb_if.wb_stb_i  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (wb_if.wb_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout %s: ack 0, expected 1 within 8 cycles", name);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        bus(1'b1, addr, data, 4'hF, 1'b0, 32'h0, "write");
    endtask

    task automatic wr_sel(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] sel);
        bus(1'b1, addr, data, sel, 1'b0, 32'h0, "write_sel");
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] expv, input string name);
        bus(1'b0, addr, 32'h0, 4'hF, 1'b1, expv, name);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: one pop per ack, ack must be a single-cycle pulse
    initial begin
        logic        ack_prev;
        logic [32:0] e;
        string       nm;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack_prev = 1'b0;
            end else begin
                if (wb_if.wb_ack_o) begin
                    n_checks++;
                    if (ack_prev) begin
                        n_fail++;
                        $display("FAIL ack_width: ack high 2 cycles, expected 1");
                    end
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_ack: ack with empty scoreboard");
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        if (e[32]) begin
                            n_checks++;
                            if (wb_if.wb_data_o !== e[31:0]) begin
                                n_fail++;
                                $display("FAIL %s: read 0x%08h, expected 0x%08h", nm, wb_if.wb_data_o, e[31:0]);
                            end
                        end
                    end
                end
                ack_prev = wb_if.wb_ack_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first;
        logic        ev2;
        logic [31:0] evm;
        logic [31:0] exp_evm;
        logic [31:0] exp_ctrl1;

        rst_n           = 1'b0;
        wb_if.wb_addr_i = '0;
        wb_if.wb_data_i = '0;
        wb_if.wb_sel_i  = '0;
        wb_if.wb_we_i   = 1'b0;
        wb_if.wb_cyc_i  = 1'b0;
        wb_if.wb_stb_i  = 1'b0;
        cycles(3);
        check("reset_irq", {31'h0, timer_irq}, 32'h0);
        check("reset_event", {28'h0, ch_event}, 32'h0);
        check("reset_ack", {31'h0, wb_if.wb_ack_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);

        // Reset values
        rd(8'h00, 32'h0, "rst_gctrl");
        rd(8'h04, 32'h0, "rst_prescale");
        rd(8'h08, 32'h0, "rst_status");
        rd(8'h0C, 32'h0, "rst_mask");
        rd(8'h20, 32'h0, "rst_load0");
        rd(8'h24, 32'h0, "rst_ctrl0");
        rd(8'h80, 32'h0, "rst_count0");

        // Byte-lane writes
        wr_sel(8'h20, 32'hAABBCCDD, 4'b0001);
        rd(8'h20, 32'h000000DD, "load0_sel0001");
        wr_sel(8'h20, 32'hAABBCCDD, 4'b0100);
        rd(8'h20, 32'h00BB00DD, "load0_sel0100");

        // Unmapped, read-only and absent-channel addresses
        rd(8'h60, 32'h0, "unmapped_60");
        wr(8'h60, 32'hFFFFFFFF);
        rd(8'h60, 32'h0, "unmapped_60_after_wr");
        wr(8'h80, 32'h00001234);
        rd(8'h80, 32'h0, "count0_ro");
        wr(8'h40, 32'h00000055);
        rd(8'h40, 32'h0, "absent_ch4_load");

        // Enable with LOAD==0 is ignored
        wr(8'h34, 32'h1);
        rd(8'h34, 32'h0, "ctrl2_load0_ignored");

        // Prescaled one-shot: 4 ticks of 4 clocks
        wr(8'h0C, 32'h1);
        wr(8'h04, 32'h3);
        wr(8'h20, 32'h4);
        wr(8'h24, 32'h1);
        wr(8'h00, 32'h1);
        first = 0;
        ev2   = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            ev2 = ev2 | ch_event[2];
            if (ch_event[0]) begin
                first = c;
                break;
            end
        end
        check("ps3_expiry_clk", 32'(first), 32'd16);
        check("ps3_irq_same_clk", {31'h0, timer_irq}, 32'h0);
        cycles(1);
        check("ps3_irq_next_clk", {31'h0, timer_irq}, 32'h1);
        check("ch2_no_event", {31'h0, ev2}, 32'h0);
        rd(8'h24, 32'h0, "ps3_ctrl0_cleared");
        rd(8'h08, 32'h1, "ps3_status");
        rd(8'h80, 32'h0, "ps3_count0");

        // Periodic channel 1, tick every clock
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);
        wr(8'h00, 32'h1);
        wr(8'h28, 32'h3);
        wr(8'h2C, 32'h3);
        evm = '0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            evm[c] = ch_event[1];
        end
`ifdef WB_TIMER_AUTORELOAD_EN
        exp_evm   = 32'h00001248;
        exp_ctrl1 = 32'h3;
`else
        exp_evm   = 32'h00000008;
        exp_ctrl1 = 32'h0;
`endif
        check("ch1_event_pattern", evm, exp_evm);
        rd(8'h2C, exp_ctrl1, "ch1_ctrl_running");
        wr(8'h2C, 32'h0);
        evm = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            evm[c] = ch_event[1];
        end
        check("ch1_stopped", evm, 32'h0);

        // Stop freezes COUNT: start at 100, one tick, then stopped
        wr(8'h38, 32'd100);
        wr(8'h3C, 32'h1);
        wr(8'h3C, 32'h0);
        rd(8'h8C, 32'd99, "ch3_frozen");
        cycles(5);
        rd(8'h8C, 32'd99, "ch3_still_frozen");
        rd(8'h3C, 32'h0, "ch3_ctrl_off");

        // W1C, and expiry beating a same-cycle clear
        wr(8'h08, 32'hF);
        rd(8'h08, 32'h0, "status_cleared");
        check("irq_after_clear", {31'h0, timer_irq}, 32'h0);
        wr(8'h20, 32'h2);
        wr(8'h24, 32'h1);
        cycles(6);
        rd(8'h08, 32'h1, "status0_set");
        check("irq_status0", {31'h0, timer_irq}, 32'h1);
        wr(8'h24, 32'h1);
        wr(8'h08, 32'h1);
        rd(8'h08, 32'h1, "set_wins_over_w1c");
        check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
        wr(8'h08, 32'h1);
        rd(8'h08, 32'h0, "w1c_plain");
        check("irq_after_w1c", {31'h0, timer_irq}, 32'h0);

        // Reset in the middle of a count
        wr(8'h28, 32'h1);
        wr(8'h2C, 32'h1);
        wr(8'h0C, 32'h3);
        wr(8'h20, 32'd10);
        wr(8'h24, 32'h1);
        rd(8'h80, 32'd9, "count0_decrement");
        check("irq_before_reset", {31'h0, timer_irq}, 32'h1);
        cycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_irq", {31'h0, timer_irq}, 32'h0);
        check("async_reset_event", {28'h0, ch_event}, 32'h0);
        cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        rd(8'h00, 32'h0, "post_rst_gctrl");
        rd(8'h04, 32'h0, "post_rst_prescale");
        rd(8'h08, 32'h0, "post_rst_status");
        rd(8'h0C, 32'h0, "post_rst_mask");
        rd(8'h20, 32'h0, "post_rst_load0");
        rd(8'h24, 32'h0, "post_rst_ctrl0");
        rd(8'h80, 32'h0, "post_rst_count0");
        rd(8'h28, 32'h0, "post_rst_load1");

        cycles(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
